// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the ALU decoder.
// Divide codes count as muldiv operations only when MULDIV_DIV_EN is defined.
package muldiv_unit_pkg;

   localparam logic [4:0] ALU_MULT  = 5'b10011;
   localparam logic [4:0] ALU_MULTU = 5'b10101;
   localparam logic [4:0] ALU_DIV   = 5'b10110;
   localparam logic [4:0] ALU_DIVU  = 5'b10111;

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   function automatic logic is_muldiv(input logic [4:0] code);
      logic hit;
      case (code)
         ALU_MULT, ALU_MULTU: hit = 1'b1;
`ifdef MULDIV_DIV_EN
         ALU_DIV, ALU_DIVU:   hit = 1'b1;
`endif
         default:             hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: radix-2 shift-add or restoring divide step.
// The divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             borrow;
`else
   logic             unused_is_div;
   assign unused_is_div = is_div;
`endif

   // Next accumulator: multiplier bit 0 gates the add, the divide path shifts in one quotient bit.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      // Top bit of the trial difference is the borrow: set when the divisor does not fit.
      trial   = {1'b0, shifted} - {2'b00, operand};
      borrow  = trial[WIDTH+1];
      if (is_div) begin
         next_hi = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], ~borrow};
      end else begin
         next_hi = sum[WIDTH:1];
         next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
`endif
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative mult/multu (and div/divu with MULDIV_DIV_EN) unit owning HI/LO.
// Operates on magnitudes for WIDTH cycles, then applies the sign fix in FIX.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [4:0]       alucontrol,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   muldiv_state_t state, next_state;

   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   acc_hi, acc_lo, operand;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   mag_a, mag_b, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] product;
   logic               neg_q, launch, op_signed, sa, sb, op_div, div_in;
`ifdef MULDIV_DIV_EN
   logic               neg_r, b_zero;
`endif

   // Launch decode: operand signs and magnitudes for the requested operation.
   always_comb begin
      launch    = (state == IDLE) && start && is_muldiv(alucontrol);
      op_signed = (alucontrol == ALU_MULT) || (alucontrol == ALU_DIV);
`ifdef MULDIV_DIV_EN
      div_in    = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
`else
      div_in    = 1'b0;
`endif
      sa        = op_signed & srca[WIDTH-1];
      sb        = op_signed & srcb[WIDTH-1];
      mag_a     = sa ? (~srca + WIDTH'(1)) : srca;
      mag_b     = sb ? (~srcb + WIDTH'(1)) : srcb;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (op_div),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (launch) next_state = CALC;
            else        next_state = IDLE;
         end
         CALC: begin
            if (count == CNT_W'(WIDTH - 1)) next_state = FIX;
            else                            next_state = CALC;
         end
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand latch at launch, one datapath step per CALC cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= {CNT_W{1'b0}};
         acc_hi  <= {WIDTH{1'b0}};
         acc_lo  <= {WIDTH{1'b0}};
         operand <= {WIDTH{1'b0}};
         neg_q   <= 1'b0;
         op_div  <= 1'b0;
`ifdef MULDIV_DIV_EN
         neg_r   <= 1'b0;
         b_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (launch) begin
                  count   <= {CNT_W{1'b0}};
                  acc_hi  <= {WIDTH{1'b0}};
                  acc_lo  <= div_in ? mag_a : mag_b;
                  operand <= div_in ? mag_b : mag_a;
                  neg_q   <= sa ^ sb;
                  op_div  <= div_in;
`ifdef MULDIV_DIV_EN
                  neg_r   <= sa;
                  b_zero  <= (srcb == {WIDTH{1'b0}});
`endif
               end
            end
            CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count + CNT_W'(1);
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

   // Sign fix; a zero divisor keeps the all-ones quotient, and the remainder fix restores srca.
   always_comb begin
      product = {acc_hi, acc_lo};
      if (neg_q) product = ~product + (2*WIDTH)'(1);
      else       product = {acc_hi, acc_lo};
      fix_hi = product[2*WIDTH-1:WIDTH];
      fix_lo = product[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (op_div) begin
         fix_lo = (neg_q && !b_zero) ? (~acc_lo + WIDTH'(1)) : acc_lo;
         fix_hi = neg_r ? (~acc_hi + WIDTH'(1)) : acc_hi;
      end else begin
         fix_hi = product[2*WIDTH-1:WIDTH];
         fix_lo = product[WIDTH-1:0];
      end
`endif
   end

   // HI/LO: result write in FIX, mthi/mtlo only while idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi   <= {WIDTH{1'b0}};
         lo   <= {WIDTH{1'b0}};
         done <= 1'b0;
      end else begin
         done <= (state == FIX);
         if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end else if (state == IDLE) begin
            if (hi_we) hi <= srca;
            if (lo_we) lo <= srca;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic reference model.
// Divide scenarios are exercised when MULDIV_DIV_EN is defined; otherwise their codes must be ignored.
module tb_muldiv_unit;

   localparam logic [4:0] C_MULT  = 5'b10011;
   localparam logic [4:0] C_MULTU = 5'b10101;
   localparam logic [4:0] C_DIV   = 5'b10110;
   localparam logic [4:0] C_DIVU  = 5'b10111;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [4:0]  alucontrol = 5'd0;
   logic [31:0] srca = 32'd0;
   logic [31:0] srcb = 32'd0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int vectors = 0;
   int errors  = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
      .srca(srca), .srcb(srcb), .hi_we(hi_we), .lo_we(lo_we),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint     sp;
      logic [63:0] p;
      int         ia, ib;
      ia = a;
      ib = b;
      eh = 32'd0;
      el = 32'd0;
      case (code)
         C_MULT: begin
            sp = longint'(ia) * longint'(ib);
            p  = sp;
            eh = p[63:32];
            el = p[31:0];
         end
         C_MULTU: begin
            p  = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
         end
         C_DIV: begin
            if (b == 32'd0) begin
               el = 32'hFFFFFFFF; eh = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               el = 32'h80000000; eh = 32'd0;
            end else begin
               el = ia / ib; eh = ia % ib;
            end
         end
         C_DIVU: begin
            if (b == 32'd0) begin
               el = 32'hFFFFFFFF; eh = a;
            end else begin
               el = a / b; eh = a % b;
            end
         end
         default: begin
            eh = 32'd0; el = 32'd0;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 6))
         0:       v = 32'd0;
         1:       v = 32'hFFFFFFFF;
         2:       v = 32'h80000000;
         3:       v = 32'd1;
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // Launch one operation and wait (bounded) for done; lat = edges after the start edge, -1 on timeout.
   task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output int lat,
                         output logic busy0, output logic busy_at_done);
      @(negedge clk);
      alucontrol = code; srca = a; srcb = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy0 = busy;
      lat = -1; rh = 32'hx; rl = 32'hx; busy_at_done = 1'bx;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i; rh = hi; rl = lo; busy_at_done = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (hi !== 32'd0)   begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'd0); end
      vectors++; if (lo !== 32'd0)   begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'd0); end
      vectors++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
      reset = 1'b1;
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      srca = 32'hDEADBEEF; hi_we = 1'b1;
      @(negedge clk);
      hi_we = 1'b0;
      vectors++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi got %h want %h", hi, 32'hDEADBEEF); end
      srca = 32'd1; lo_we = 1'b1;
      @(negedge clk);
      lo_we = 1'b0;
      vectors++; if (lo !== 32'd1)        begin errors++; $display("FAIL mtlo got %h want %h", lo, 32'd1); end
      vectors++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_hi_kept got %h want %h", hi, 32'hDEADBEEF); end
   endtask

   task automatic test_mult_directed();
      logic [31:0] rh, rl;
      int lat;
      logic b0, bd;
      run_op(C_MULT, 32'd7, 32'hFFFFFFFD, rh, rl, lat, b0, bd);
      vectors++; if (b0 !== 1'b1)        begin errors++; $display("FAIL mult_busy got %b want 1", b0); end
      vectors++; if (lat !== 33)         begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
      vectors++; if (bd !== 1'b0)        begin errors++; $display("FAIL mult_busy_at_done got %b want 0", bd); end
      vectors++; if (rh !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want %h", rh, 32'hFFFFFFFF); end
      vectors++; if (rl !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want %h", rl, 32'hFFFFFFEB); end
      run_op(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, lat, b0, bd);
      vectors++; if (rh !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want %h", rh, 32'hFFFFFFFE); end
      vectors++; if (rl !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want %h", rl, 32'h00000001); end
   endtask

   task automatic test_mult_random();
      logic [31:0] a, b, rh, rl, eh, el;
      logic [4:0]  code;
      int lat;
      logic b0, bd;
      for (int n = 0; n < 24; n++) begin
         code = ($urandom_range(0, 1) == 0) ? C_MULT : C_MULTU;
         a = pick(); b = pick();
         model(code, a, b, eh, el);
         run_op(code, a, b, rh, rl, lat, b0, bd);
         vectors++;
         if (lat !== 33 || rh !== eh || rl !== el) begin
            errors++;
            $display("FAIL mult_rand op=%b a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=33",
                     code, a, b, rh, rl, lat, eh, el);
         end
      end
   endtask

`ifdef MULDIV_DIV_EN
   task automatic test_div();
      logic [31:0] a, b, rh, rl, eh, el;
      logic [4:0]  code;
      int lat;
      logic b0, bd;
      run_op(C_DIV, 32'hFFFFFFF9, 32'd2, rh, rl, lat, b0, bd);
      vectors++; if (lat !== 33)          begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
      vectors++; if (rl !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want %h", rl, 32'hFFFFFFFD); end
      vectors++; if (rh !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want %h", rh, 32'hFFFFFFFF); end
      run_op(C_DIVU, 32'd100, 32'd0, rh, rl, lat, b0, bd);
      vectors++; if (rl !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero_lo got %h want %h", rl, 32'hFFFFFFFF); end
      vectors++; if (rh !== 32'h00000064) begin errors++; $display("FAIL divu_zero_hi got %h want %h", rh, 32'h00000064); end
      run_op(C_DIV, 32'hFFFFFF9C, 32'd0, rh, rl, lat, b0, bd);
      vectors++; if (rl !== 32'hFFFFFFFF || rh !== 32'hFFFFFF9C) begin
         errors++; $display("FAIL div_zero_neg got hi=%h lo=%h want hi=%h lo=%h", rh, rl, 32'hFFFFFF9C, 32'hFFFFFFFF);
      end
      run_op(C_DIV, 32'h80000000, 32'hFFFFFFFF, rh, rl, lat, b0, bd);
      vectors++; if (rl !== 32'h80000000 || rh !== 32'd0) begin
         errors++; $display("FAIL div_overflow got hi=%h lo=%h want hi=%h lo=%h", rh, rl, 32'd0, 32'h80000000);
      end
      for (int n = 0; n < 20; n++) begin
         code = ($urandom_range(0, 1) == 0) ? C_DIV : C_DIVU;
         a = pick();
         b = ($urandom_range(0, 3) == 0) ? pick() : ($urandom() >> $urandom_range(0, 31));
         model(code, a, b, eh, el);
         run_op(code, a, b, rh, rl, lat, b0, bd);
         vectors++;
         if (lat !== 33 || rh !== eh || rl !== el) begin
            errors++;
            $display("FAIL div_rand op=%b a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=33",
                     code, a, b, rh, rl, lat, eh, el);
         end
      end
   endtask
`else
   task automatic test_div();
      logic [31:0] h0, l0;
      int pulses;
      h0 = hi; l0 = lo;
      pulses = 0;
      @(negedge clk);
      alucontrol = C_DIV; srca = 32'd77; srcb = 32'd7; start = 1'b1;
      @(negedge clk);
      alucontrol = C_DIVU;
      @(negedge clk);
      start = 1'b0;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL div_disabled_busy got %b want 0", busy); end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      vectors++; if (pulses !== 0) begin errors++; $display("FAIL div_disabled_done got %0d pulses want 0", pulses); end
      vectors++; if (hi !== h0 || lo !== l0) begin
         errors++; $display("FAIL div_disabled_hilo got hi=%h lo=%h want hi=%h lo=%h", hi, lo, h0, l0);
      end
   endtask
`endif

   task automatic test_reset_midop();
      logic [31:0] rh, rl;
      int lat, pulses;
      logic b0, bd;
      pulses = 0;
      @(negedge clk);
      alucontrol = C_MULT; srca = 32'd12345; srcb = 32'd678; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b want 1", busy); end
      #2 reset = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midop_busy got %b want 0", busy); end
      vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin
         errors++; $display("FAIL midop_hilo got hi=%h lo=%h want 0 0", hi, lo);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      vectors++; if (pulses !== 0) begin errors++; $display("FAIL midop_done got %0d pulses want 0", pulses); end
      run_op(C_MULTU, 32'd3, 32'd5, rh, rl, lat, b0, bd);
      vectors++; if (rl !== 32'd15 || rh !== 32'd0 || lat !== 33) begin
         errors++; $display("FAIL midop_rerun got hi=%h lo=%h lat=%0d want hi=0 lo=f lat=33", rh, rl, lat);
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] eh, el, rh, rl;
      int lat, pulses;
      pulses = 0; lat = -1; rh = 32'd0; rl = 32'd0;
      model(C_MULT, 32'h00012345, 32'hFFFF0001, eh, el);
      @(negedge clk);
      alucontrol = C_MULT; srca = 32'h00012345; srcb = 32'hFFFF0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      srca = 32'h0BADF00D; srcb = 32'd9; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      for (int i = 6; i <= 80; i++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (lat < 0) begin lat = i; rh = hi; rl = lo; end
         end
      end
      vectors++; if (pulses !== 1) begin errors++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
      vectors++; if (lat !== 33)   begin errors++; $display("FAIL busy_ignore_latency got %0d want 33", lat); end
      vectors++; if (rh !== eh || rl !== el) begin
         errors++; $display("FAIL busy_ignore_result got hi=%h lo=%h want hi=%h lo=%h", rh, rl, eh, el);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, rh, rl, eh, el;
      int lat;
      logic b0, bd;
      for (int n = 0; n < 3; n++) begin
         a = $urandom(); b = $urandom();
         model(C_MULTU, a, b, eh, el);
         run_op(C_MULTU, a, b, rh, rl, lat, b0, bd);
         vectors++;
         if (lat !== 33 || rh !== eh || rl !== el) begin
            errors++;
            $display("FAIL back_to_back a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=33",
                     a, b, rh, rl, lat, eh, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_mult_directed();
      test_mult_random();
      test_div();
      test_reset_midop();
      test_busy_ignore();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
